// File: rtl/wb_port_ctrl.sv
// wb_port_ctrl: round-robin arbiter for ALU and load write-back onto one register-file write port,
// plus a 32-cycle sweep that zeroes every register. Optional macro WB_ZERO_GUARD_EN suppresses writes to register 0.
module wb_port_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        clrStart,
  output logic        clrBusy,
  input  logic        aluValid,
  output logic        aluReady,
  input  logic [4:0]  aluReg,
  input  logic [31:0] aluData,
  input  logic        memValid,
  output logic        memReady,
  input  logic [4:0]  memReg,
  input  logic [31:0] memData,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData
);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  sweep_cnt_r;
  logic        last_grant_r;
  logic        grant_alu_s;
  logic        grant_mem_s;
  logic        xfer_s;
  logic        xfer_we_s;
  logic [4:0]  xfer_reg_s;
  logic [31:0] xfer_data_s;
  logic        reg_write_r;
  logic [4:0]  write_reg_r;
  logic [31:0] write_data_r;
  logic        clr_busy_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ARB;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: a clear runs until register 31 has been presented, clrStart is ignored meanwhile
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ARB: begin
        if (clrStart) state_s = ST_CLEAR;
        else          state_s = ST_ARB;
      end
      ST_CLEAR: begin
        if (sweep_cnt_r == 5'd31) state_s = ST_ARB;
        else                      state_s = ST_CLEAR;
      end
      default: state_s = ST_ARB;
    endcase
  end

  // Grant decode: the pointer names the last winner, so a tie goes to the other requester
  always_comb begin
    grant_alu_s = 1'b0;
    grant_mem_s = 1'b0;
    if (!reset && (state_r == ST_ARB) && !clrStart) begin
      if (aluValid && memValid) begin
        if (last_grant_r == GNT_ALU) grant_mem_s = 1'b1;
        else                         grant_alu_s = 1'b1;
      end else if (aluValid) begin
        grant_alu_s = 1'b1;
      end else if (memValid) begin
        grant_mem_s = 1'b1;
      end else begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
      end
    end else begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
    end
  end

  assign aluReady    = grant_alu_s;
  assign memReady    = grant_mem_s;
  assign xfer_s      = grant_alu_s | grant_mem_s;
  assign xfer_reg_s  = grant_mem_s ? memReg  : aluReg;
  assign xfer_data_s = grant_mem_s ? memData : aluData;

`ifdef WB_ZERO_GUARD_EN
  assign xfer_we_s = xfer_s && (xfer_reg_s != 5'd0);
`else
  assign xfer_we_s = xfer_s;
`endif

  // Write-port registers, sweep counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_r  <= 1'b0;
      write_reg_r  <= 5'd0;
      write_data_r <= 32'd0;
      clr_busy_r   <= 1'b0;
      sweep_cnt_r  <= 5'd0;
      last_grant_r <= GNT_ALU;
    end else begin
      case (state_r)
        ST_ARB: begin
          if (clrStart) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= 5'd0;
            write_data_r <= 32'd0;
            clr_busy_r   <= 1'b1;
            sweep_cnt_r  <= 5'd1;
          end else if (xfer_s) begin
            reg_write_r  <= xfer_we_s;
            write_reg_r  <= xfer_reg_s;
            write_data_r <= xfer_data_s;
            clr_busy_r   <= 1'b0;
            last_grant_r <= grant_mem_s;
          end else begin
            reg_write_r <= 1'b0;
            clr_busy_r  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          reg_write_r  <= 1'b1;
          write_reg_r  <= sweep_cnt_r;
          write_data_r <= 32'd0;
          clr_busy_r   <= 1'b1;
          sweep_cnt_r  <= (sweep_cnt_r == 5'd31) ? 5'd0 : sweep_cnt_r + 5'd1;
        end
        default: begin
          reg_write_r <= 1'b0;
          clr_busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign regWrite  = reg_write_r;
  assign writeReg  = write_reg_r;
  assign writeData = write_data_r;
  assign clrBusy   = clr_busy_r;

endmodule

// File: tb/tb_wb_port_ctrl.sv
// Testbench for wb_port_ctrl: directed scenarios and random traffic checked against a
// transaction-level model (queue of expected write-port contents, busy countdown, tie pointer).
module tb_wb_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clrStart;
  logic        clrBusy;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluReg;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memReg;
  logic [31:0] memData;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  wb_port_ctrl dut (
    .clk(clk), .reset(reset), .clrStart(clrStart), .clrBusy(clrBusy),
    .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        busy;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  int tests = 0;
  int fails = 0;

  // reference model state
  wr_t         wq[$];
  int          m_block;
  bit          m_last_mem;
  logic        exp_ar, exp_mr, exp_we, exp_busy;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;

  // Advance the model by one cycle using the inputs currently driven.
  task automatic model_step();
    wr_t cur;
    wr_t nw;
    bit  pick_mem;
    cur = '0;
    if (wq.size() > 0) cur = wq.pop_front();
    exp_we = cur.we; exp_busy = cur.busy; exp_reg = cur.r; exp_data = cur.d;
    exp_ar = 1'b0; exp_mr = 1'b0;
    if (reset) begin
      wq.delete();
      m_block = 0;
      m_last_mem = 1'b0;
    end else if (m_block > 0) begin
      m_block--;
    end else if (clrStart) begin
      m_block = 31;
      for (int k = 0; k < 32; k++) begin
        nw.we = 1'b1; nw.busy = 1'b1; nw.r = k[4:0]; nw.d = 32'd0;
        wq.push_back(nw);
      end
    end else if (aluValid || memValid) begin
      pick_mem = (aluValid && memValid) ? !m_last_mem : memValid;
      exp_ar = !pick_mem;
      exp_mr = pick_mem;
      m_last_mem = pick_mem;
      nw.r = pick_mem ? memReg : aluReg;
      nw.d = pick_mem ? memData : aluData;
      nw.busy = 1'b0;
`ifdef WB_ZERO_GUARD_EN
      nw.we = (nw.r != 5'd0);
`else
      nw.we = 1'b1;
`endif
      wq.push_back(nw);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; clrStart = 1'b0;
    aluValid = 1'b0; aluReg = 5'd0; aluData = 32'd0;
    memValid = 1'b0; memReg = 5'd0; memData = 32'd0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      reset = (c < 2) ? 1'b1 : 1'b0;
      aluValid = 1'b1; aluReg = 5'd3; aluData = 32'h1234_5678;
      if (c == 2) aluValid = 1'b0;
      model_step();
      @(negedge clk);
      tests++; if ({aluReady, memReady} !== {exp_ar, exp_mr}) begin fails++; $display("FAIL reset_ready c%0d: got %b%b want %b%b", c, aluReady, memReady, exp_ar, exp_mr); end
      if (c > 0) begin
        tests++; if ({regWrite, clrBusy} !== 2'b00) begin fails++; $display("FAIL reset_ctl c%0d: got we=%b busy=%b want 0 0", c, regWrite, clrBusy); end
        tests++; if ({writeReg, writeData} !== 37'd0) begin fails++; $display("FAIL reset_data c%0d: got reg=%0d data=%h want 0 0", c, writeReg, writeData); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_alu();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (c == 0) begin aluValid = 1'b1; aluReg = 5'd5; aluData = 32'hDEADBEEF; end
      model_step();
      @(negedge clk);
      tests++; if ({aluReady, memReady} !== {exp_ar, exp_mr}) begin fails++; $display("FAIL single_ready c%0d: got %b%b want %b%b", c, aluReady, memReady, exp_ar, exp_mr); end
      tests++; if (regWrite !== exp_we) begin fails++; $display("FAIL single_we c%0d: got %b want %b", c, regWrite, exp_we); end
      tests++; if (clrBusy !== exp_busy) begin fails++; $display("FAIL single_busy c%0d: got %b want %b", c, clrBusy, exp_busy); end
      if (exp_we) begin tests++; if ({writeReg, writeData} !== {exp_reg, exp_data}) begin fails++; $display("FAIL single_data c%0d: got %0d/%h want %0d/%h", c, writeReg, writeData, exp_reg, exp_data); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0) reset = 1'b1;
      if (c >= 1 && c <= 4) begin
        aluValid = 1'b1; aluReg = 5'd1; aluData = 32'h0000_00A1;
        memValid = 1'b1; memReg = 5'd2; memData = 32'h0000_00B2;
      end
      model_step();
      @(negedge clk);
      tests++; if ({aluReady, memReady} !== {exp_ar, exp_mr}) begin fails++; $display("FAIL rr_ready c%0d: got %b%b want %b%b", c, aluReady, memReady, exp_ar, exp_mr); end
      tests++; if (regWrite !== exp_we) begin fails++; $display("FAIL rr_we c%0d: got %b want %b", c, regWrite, exp_we); end
      tests++; if (clrBusy !== exp_busy) begin fails++; $display("FAIL rr_busy c%0d: got %b want %b", c, clrBusy, exp_busy); end
      if (exp_we) begin tests++; if ({writeReg, writeData} !== {exp_reg, exp_data}) begin fails++; $display("FAIL rr_data c%0d: got %0d/%h want %0d/%h", c, writeReg, writeData, exp_reg, exp_data); end end
      @(posedge clk); #1;
    end
  endtask

  // Clear with both requesters waiting, plus a second clrStart pulse mid-sweep.
  task automatic test_clear();
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      clrStart = (c == 0 || c == 5) ? 1'b1 : 1'b0;
      if (c < 38) begin
        aluValid = 1'b1; aluReg = 5'd9;  aluData = 32'h0000_0C09;
        memValid = 1'b1; memReg = 5'd17; memData = 32'h0000_0C17;
      end
      model_step();
      @(negedge clk);
      tests++; if ({aluReady, memReady} !== {exp_ar, exp_mr}) begin fails++; $display("FAIL clear_ready c%0d: got %b%b want %b%b", c, aluReady, memReady, exp_ar, exp_mr); end
      tests++; if (regWrite !== exp_we) begin fails++; $display("FAIL clear_we c%0d: got %b want %b", c, regWrite, exp_we); end
      tests++; if (clrBusy !== exp_busy) begin fails++; $display("FAIL clear_busy c%0d: got %b want %b", c, clrBusy, exp_busy); end
      if (exp_we) begin tests++; if ({writeReg, writeData} !== {exp_reg, exp_data}) begin fails++; $display("FAIL clear_data c%0d: got %0d/%h want %0d/%h", c, writeReg, writeData, exp_reg, exp_data); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int c = 0; c < 15; c++) begin
      idle_inputs();
      clrStart = (c == 0) ? 1'b1 : 1'b0;
      reset    = (c == 10) ? 1'b1 : 1'b0;
      aluValid = (c < 12) ? 1'b1 : 1'b0; aluReg = 5'd12; aluData = 32'h0BAD_F00D;
      model_step();
      @(negedge clk);
      tests++; if ({aluReady, memReady} !== {exp_ar, exp_mr}) begin fails++; $display("FAIL rstclr_ready c%0d: got %b%b want %b%b", c, aluReady, memReady, exp_ar, exp_mr); end
      tests++; if (regWrite !== exp_we) begin fails++; $display("FAIL rstclr_we c%0d: got %b want %b", c, regWrite, exp_we); end
      tests++; if (clrBusy !== exp_busy) begin fails++; $display("FAIL rstclr_busy c%0d: got %b want %b", c, clrBusy, exp_busy); end
      if (exp_we) begin tests++; if ({writeReg, writeData} !== {exp_reg, exp_data}) begin fails++; $display("FAIL rstclr_data c%0d: got %0d/%h want %0d/%h", c, writeReg, writeData, exp_reg, exp_data); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (c == 0) begin memValid = 1'b1; memReg = 5'd0; memData = 32'd7; end
      model_step();
      @(negedge clk);
      tests++; if ({aluReady, memReady} !== {exp_ar, exp_mr}) begin fails++; $display("FAIL zero_ready c%0d: got %b%b want %b%b", c, aluReady, memReady, exp_ar, exp_mr); end
      tests++; if (regWrite !== exp_we) begin fails++; $display("FAIL zero_we c%0d: got %b want %b", c, regWrite, exp_we); end
      tests++; if (clrBusy !== exp_busy) begin fails++; $display("FAIL zero_busy c%0d: got %b want %b", c, clrBusy, exp_busy); end
      if (exp_we) begin tests++; if ({writeReg, writeData} !== {exp_reg, exp_data}) begin fails++; $display("FAIL zero_data c%0d: got %0d/%h want %0d/%h", c, writeReg, writeData, exp_reg, exp_data); end end
      @(posedge clk); #1;
    end
  endtask

  // Random traffic; a requester that was not accepted keeps its request unchanged.
  task automatic test_random();
    bit hold_a = 1'b0;
    bit hold_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(0, 149) == 0);
      clrStart = ($urandom_range(0, 39) == 0);
      if (!hold_a) begin
        aluValid = ($urandom_range(0, 2) != 0);
        aluReg   = 5'($urandom_range(0, 31));
        aluData  = $urandom;
      end
      if (!hold_m) begin
        memValid = ($urandom_range(0, 2) != 0);
        memReg   = 5'($urandom_range(0, 31));
        memData  = $urandom;
      end
      model_step();
      @(negedge clk);
      tests++; if ({aluReady, memReady} !== {exp_ar, exp_mr}) begin fails++; $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, aluReady, memReady, exp_ar, exp_mr); end
      tests++; if (regWrite !== exp_we) begin fails++; $display("FAIL rand_we c%0d: got %b want %b", c, regWrite, exp_we); end
      tests++; if (clrBusy !== exp_busy) begin fails++; $display("FAIL rand_busy c%0d: got %b want %b", c, clrBusy, exp_busy); end
      if (exp_we) begin tests++; if ({writeReg, writeData} !== {exp_reg, exp_data}) begin fails++; $display("FAIL rand_data c%0d: got %0d/%h want %0d/%h", c, writeReg, writeData, exp_reg, exp_data); end end
      hold_a = aluValid && !exp_ar;
      hold_m = memValid && !exp_mr;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    m_block = 0;
    m_last_mem = 1'b0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_alu();
    test_round_robin();
    test_clear();
    test_reset_mid_clear();
    test_zero_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_ctrl.md
WB_PORT_CTRL -- requirements
Module: wb_port_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: clrStart  input  1  one-cycle request to zero all 32 registers.
REQ-004 SHALL have port: clrBusy  output  1  high in every cycle a clear-sweep write is presented.
REQ-005 SHALL have ports: aluValid input 1, aluReady output 1, aluReg input 5, aluData input 32; ALU write-back requester.
REQ-006 SHALL have ports: memValid input 1, memReady output 1, memReg input 5, memData input 32; load write-back requester.
REQ-007 SHALL have ports: regWrite output 1, writeReg output 5, writeData output 32; drive the register file's single write port, all registered.

Function
REQ-008 SHALL implement states ARB and CLEAR only.
REQ-009 SHALL, in ARB, accept a requester when its valid and ready are both high in the same cycle (transfer).
REQ-010 SHALL grant at most one requester per cycle; ready is combinational: high only for the granted requester, low otherwise.
REQ-011 SHALL grant a lone valid requester immediately; with both valid, grant the one not granted last (round-robin pointer lastGrant).
REQ-012 SHALL update lastGrant only on a transfer.
REQ-013 SHALL present a transfer accepted in cycle T on regWrite/writeReg/writeData in cycle T+1 (latency 1); regWrite low in any cycle with no transfer or clear write.
REQ-014 SHALL treat clrStart in ARB as higher priority than both requesters: both ready low in that cycle T, state goes CLEAR.
REQ-015 SHALL, for a clear started in T, present regWrite=1, writeData=0, writeReg=0..31 ascending in cycles T+1..T+32, one register per cycle.
REQ-016 SHALL hold aluReady and memReady low in cycles T..T+31 and return to ARB so a grant may occur in T+32.
REQ-017 SHALL assert clrBusy exactly in cycles T+1..T+32.
REQ-018 SHALL ignore clrStart while in CLEAR (no restart, no extension).
REQ-019 SHALL hold unaccepted request data untouched; requesters keep valid/reg/data stable until ready.
REQ-020 SHALL use a 5-bit sweep counter that does not wrap into a second sweep after register 31.

Reset
REQ-021 SHALL, when reset is high at a rising edge, set state=ARB, sweep counter=0, lastGrant=ALU, regWrite=0, writeReg=0, writeData=0, clrBusy=0.
REQ-022 SHALL drive aluReady=0 and memReady=0 in any cycle reset is high.
REQ-023 SHALL abort a clear sweep in progress on reset; registers not yet swept are not written.
REQ-024 SHALL give memory the first tie win after reset (lastGrant=ALU).

Configuration
REQ-025 SHALL honour macro WB_ZERO_GUARD_EN: when defined, a transfer targeting register 0 is accepted (ready high) but produces regWrite=0 in T+1; lastGrant still updates.
REQ-026 SHALL, when WB_ZERO_GUARD_EN is undefined, write register-0 transfers like any other.
REQ-027 SHALL write register 0 during a clear sweep regardless of WB_ZERO_GUARD_EN.

Verification
REQ-028 SHALL cover: aluValid=1, aluReg=5, aluData=32'hDEADBEEF alone in cycle T -> aluReady=1 in T; regWrite=1, writeReg=5, writeData=32'hDEADBEEF in T+1.
REQ-029 SHALL cover: after reset, both valid for 4 cycles (aluReg=1, memReg=2) -> grants MEM, ALU, MEM, ALU; writeReg 2,1,2,1 in T+1..T+4.
REQ-030 SHALL cover: clrStart with both valid in T -> both ready low T..T+31; writeReg 0..31 with writeData=0 in T+1..T+32; clrBusy high T+1..T+32; first grant in T+32.
REQ-031 SHALL cover: reset in T+10 of a sweep -> regWrite=0 and clrBusy=0 in T+11; ready may rise in T+11; no clear writes after T+10.
REQ-032 SHALL cover: memReg=0, memData=7 transfer -> with WB_ZERO_GUARD_EN regWrite=0 next cycle; without it regWrite=1, writeReg=0, writeData=7.
REQ-033 SHALL cover: clrStart pulsed at T+5 during sweep -> sweep still ends with writeReg=31 at T+32; no second sweep.
